// File: rtl/frame_buf_reader_pkg.sv
// Shared constants, state encoding and sync payload for the camera frame buffer.
package frame_buf_reader_pkg;

    localparam int unsigned LOGSIZE      = 19;
    localparam int unsigned WIDTH        = 24;
    localparam int unsigned H_ACTIVE     = 640;
    localparam int unsigned V_ACTIVE     = 480;
    localparam int unsigned FRAME_PIXELS = H_ACTIVE * V_ACTIVE;
    localparam int unsigned HCOUNT_W     = 11;
    localparam int unsigned VCOUNT_W     = 10;

    typedef enum logic [1:0] {
        WAIT_FIRST   = 2'd0,
        DISPLAY      = 2'd1,
        SWAP_PENDING = 2'd2
    } rd_state_e;

    // VGA timing bundle carried alongside the pixel pipeline
    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register; resets to all ones so active-low syncs stay idle.
module sync_delay_line #(
    parameter int unsigned DEPTH = 3,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stages;

    // Shift one stage per clock
    always_ff @(posedge clk) begin
        if (reset) begin
            stages <= '1;
        end else begin
            stages[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign dout = stages[DEPTH-1];

endmodule

// File: rtl/frame_buf_reader.sv
// Display-side frame buffer reader: raster address generation, ping-pong bank
// ownership with tear-free swaps at the first blank line, and pixel/sync output
// aligned three cycles behind hcount/vcount.
module frame_buf_reader #(
    parameter int unsigned LOGSIZE  = frame_buf_reader_pkg::LOGSIZE,
    parameter int unsigned WIDTH    = frame_buf_reader_pkg::WIDTH,
    parameter int unsigned H_ACTIVE = frame_buf_reader_pkg::H_ACTIVE,
    parameter int unsigned V_ACTIVE = frame_buf_reader_pkg::V_ACTIVE
) (
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [frame_buf_reader_pkg::HCOUNT_W-1:0] hcount,
    input  logic [frame_buf_reader_pkg::VCOUNT_W-1:0] vcount,
    input  logic                                      hsync,
    input  logic                                      vsync,
    input  logic                                      blank,
    input  logic                                      frame_done,
    output logic [LOGSIZE:0]                          rd_addr,
    input  logic [WIDTH-1:0]                          rd_data,
    output logic                                      write_bank,
    output logic [WIDTH-1:0]                          pixel_out,
    output logic                                      hsync_out,
    output logic                                      vsync_out,
    output logic                                      blank_out,
    output logic                                      frame_dropped
);

    import frame_buf_reader_pkg::*;

    localparam int unsigned        FRAME   = H_ACTIVE * V_ACTIVE;
    localparam logic [LOGSIZE-1:0] OFF_MAX = LOGSIZE'(FRAME - 1);
    localparam logic [HCOUNT_W-1:0] H_LIM  = HCOUNT_W'(H_ACTIVE);
    localparam logic [VCOUNT_W-1:0] V_LIM  = VCOUNT_W'(V_ACTIVE);

    rd_state_e          state, state_nx;
    logic               read_bank;
    logic               shown;
    logic [LOGSIZE-1:0] offset;
    logic               active_c, frame_start_c, boundary_c;
    logic               swap_c, drop_c;
    logic [WIDTH-1:0]   pixel_c;
    sync_t              sync_in, sync_d2, sync_d3;

    assign active_c      = (hcount < H_LIM) && (vcount < V_LIM);
    assign frame_start_c = (hcount == '0) && (vcount == '0);
    assign boundary_c    = (hcount == '0) && (vcount == V_LIM);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_FIRST;
        end else begin
            state <= state_nx;
        end
    end

    // Next state, swap and drop decisions
    always_comb begin
        state_nx = state;
        swap_c   = 1'b0;
        drop_c   = 1'b0;
        case (state)
            WAIT_FIRST, DISPLAY: begin
                if (frame_done) begin
                    state_nx = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (boundary_c) begin
                    // A frame_done landing on the swap cycle is counted as dropped
                    swap_c   = 1'b1;
                    drop_c   = frame_done;
                    state_nx = DISPLAY;
                end else if (frame_done) begin
                    drop_c = 1'b1;
                end
            end
            default: state_nx = WAIT_FIRST;
        endcase
    end

    // Bank ownership, displayed-frame flag and drop pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            read_bank     <= 1'b1;
            write_bank    <= 1'b0;
            shown         <= 1'b0;
            frame_dropped <= 1'b0;
        end else begin
            frame_dropped <= drop_c;
            if (swap_c) begin
                read_bank  <= write_bank;
                write_bank <= ~write_bank;
                shown      <= 1'b1;
            end
        end
    end

    // Raster offset counter and registered read address; offset clamps at last pixel
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr <= '0;
            offset  <= '0;
        end else if (frame_start_c) begin
            rd_addr <= {read_bank, LOGSIZE'(0)};
            offset  <= LOGSIZE'(active_c);
        end else begin
            rd_addr <= {read_bank, offset};
            if (active_c && (offset != OFF_MAX)) begin
                offset <= offset + LOGSIZE'(1);
            end
        end
    end

    assign sync_in = '{hsync: hsync, vsync: vsync, blank: blank};

    sync_delay_line #(
        .DEPTH (2),
        .WIDTH ($bits(sync_t))
    ) u_sync_d2 (
        .clk   (clk),
        .reset (reset),
        .din   (sync_in),
        .dout  (sync_d2)
    );

    sync_delay_line #(
        .DEPTH (1),
        .WIDTH ($bits(sync_t))
    ) u_sync_d3 (
        .clk   (clk),
        .reset (reset),
        .din   (sync_d2),
        .dout  (sync_d3)
    );

    assign hsync_out = sync_d3.hsync;
    assign vsync_out = sync_d3.vsync;
    assign blank_out = sync_d3.blank;

    // Black while blanked or before the first completed swap
    assign pixel_c = (sync_d2.blank || !shown) ? '0 : rd_data;

    // Pixel output register, lines up with the third sync stage
    always_ff @(posedge clk) begin
        if (reset) begin
            pixel_out <= '0;
        end else begin
            pixel_out <= pixel_c;
        end
    end

endmodule

// File: tb/tb_frame_buf_reader.sv
// Randomised bench for frame_buf_reader with a behavioural frame-buffer model.
module tb_frame_buf_reader;

    localparam int FP = 640 * 480;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync = 1'b1, vsync = 1'b1, blank = 1'b0, frame_done = 1'b0;
    logic [19:0] rd_addr;
    logic [23:0] rd_data;
    logic        write_bank, hsync_out, vsync_out, blank_out, frame_dropped;
    logic [23:0] pixel_out;

    // Small instance used only to reach offset saturation cheaply
    logic        s_reset = 1'b1;
    logic [10:0] s_hcount = '0;
    logic [9:0]  s_vcount = '0;
    logic [5:0]  s_rd_addr;
    logic [7:0]  s_rd_data = '0;
    logic [7:0]  s_pixel_out;
    logic        s_write_bank, s_hsync_out, s_vsync_out, s_blank_out, s_frame_dropped;

    int errs = 0, checks = 0, obs_drops = 0;
    bit check_en = 0, mark_in = 0;
    bit [2:0] mark_d = '0;

    always #5 clk = ~clk;

    frame_buf_reader dut (
        .clk(clk), .reset(reset), .hcount(hcount), .vcount(vcount),
        .hsync(hsync), .vsync(vsync), .blank(blank), .frame_done(frame_done),
        .rd_addr(rd_addr), .rd_data(rd_data), .write_bank(write_bank),
        .pixel_out(pixel_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .blank_out(blank_out), .frame_dropped(frame_dropped)
    );

    frame_buf_reader #(.LOGSIZE(5), .WIDTH(8), .H_ACTIVE(8), .V_ACTIVE(4)) dut_s (
        .clk(clk), .reset(s_reset), .hcount(s_hcount), .vcount(s_vcount),
        .hsync(1'b1), .vsync(1'b1), .blank(1'b0), .frame_done(1'b0),
        .rd_addr(s_rd_addr), .rd_data(s_rd_data), .write_bank(s_write_bank),
        .pixel_out(s_pixel_out), .hsync_out(s_hsync_out), .vsync_out(s_vsync_out),
        .blank_out(s_blank_out), .frame_dropped(s_frame_dropped)
    );

    // Registered-read BRAM whose contents equal the in-bank address
    always @(posedge clk) rd_data <= 24'(rd_addr[18:0]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: bank ownership rules, clamped active-pixel count, 3-cycle alignment
    int          m_cnt = 0;
    bit          m_wb = 0, m_rb = 1, m_pend = 0, m_have = 0, exp_drop = 0;
    logic [19:0] exp_addr = '0;
    logic [23:0] exp_pix = '0;
    bit   [2:0]  d_hs = '1, d_vs = '1, d_bl = '1;
    logic [18:0] d_off [2] = '{19'd0, 19'd0};

    always @(posedge clk) begin : model
        automatic bit at_start = (hcount == 0) && (vcount == 0);
        automatic bit act      = (hcount < 640) && (vcount < 480);
        automatic bit bnd      = (hcount == 0) && (vcount == 480);
        automatic int off      = at_start ? 0 : ((m_cnt > FP - 1) ? FP - 1 : m_cnt);
        if (reset) begin
            m_cnt <= 0; m_wb <= 0; m_rb <= 1; m_pend <= 0; m_have <= 0;
            exp_drop <= 0; exp_addr <= '0; exp_pix <= '0;
            d_hs <= '1; d_vs <= '1; d_bl <= '1;
            d_off[0] <= '0; d_off[1] <= '0;
        end else begin
            exp_addr <= {m_rb, 19'(off)};
            m_cnt    <= at_start ? int'(act) : m_cnt + int'(act);
            exp_pix  <= (d_bl[1] || !m_have) ? 24'd0 : 24'(d_off[1]);
            d_hs <= {d_hs[1:0], hsync};
            d_vs <= {d_vs[1:0], vsync};
            d_bl <= {d_bl[1:0], blank};
            d_off[0] <= 19'(off);
            d_off[1] <= d_off[0];
            exp_drop <= 0;
            if (m_pend && bnd) begin
                m_rb <= m_wb; m_wb <= !m_wb; m_pend <= 0; m_have <= 1;
                exp_drop <= frame_done;
            end else if (m_pend && frame_done) begin
                exp_drop <= 1;
            end else if (frame_done) begin
                m_pend <= 1;
            end
        end
    end

    always @(posedge clk) mark_d <= {mark_d[1:0], mark_in};

    // Per-cycle comparison against the model
    always @(posedge clk) begin
        #1;
        if (check_en) begin
            chk("rd_addr", rd_addr, exp_addr);
            chk("write_bank", write_bank, m_wb);
            chk("pixel_out", pixel_out, exp_pix);
            chk("hsync_out", hsync_out, d_hs[2]);
            chk("vsync_out", vsync_out, d_vs[2]);
            chk("blank_out", blank_out, d_bl[2]);
            chk("frame_dropped", frame_dropped, exp_drop);
            if (blank_out) chk("black_when_blank", pixel_out, 0);
            if (frame_dropped) obs_drops++;
            if (mark_d[2]) begin
                chk("pixel_h5_v2", pixel_out, 1285);
                chk("blank_h5_v2", blank_out, 0);
            end
        end
    end

    task automatic step(input int h, input int v, input bit fd, input bit rst, input bit mk);
        @(negedge clk);
        hcount     = 11'(h);
        vcount     = 10'(v);
        frame_done = fd;
        reset      = rst;
        blank      = !(h < 640 && v < 480);
        hsync      = !(h >= 642 && h <= 645);
        vsync      = !(v == 481 || v == 482);
        mark_in    = mk;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_rd_addr"}, rd_addr, 0);
        chk({tag, "_write_bank"}, write_bank, 0);
        chk({tag, "_pixel_out"}, pixel_out, 0);
        chk({tag, "_hsync_out"}, hsync_out, 1);
        chk({tag, "_vsync_out"}, vsync_out, 1);
        chk({tag, "_blank_out"}, blank_out, 1);
        chk({tag, "_frame_dropped"}, frame_dropped, 0);
    endtask

    // Compressed raster: three full lines, three sampled lines, four short blank lines
    task automatic run_frame(input int f);
        int lines [10] = '{0, 1, 2, 100, 240, 479, 480, 481, 482, 483};
        for (int li = 0; li < 10; li++) begin
            int v = lines[li];
            int hmax = (v < 480) ? 648 : 16;
            for (int h = 0; h < hmax; h++) begin
                bit fd = 0;
                bit bnd = (h == 0 && v == 480);
                bit rst = (f == 6 && h == 0 && v == 240);
                bit mk  = (f == 2 && h == 5 && v == 2);
                case (f)
                    1: fd = (h == 10 && v == 100);
                    2: fd = (h == 10 && (v == 100 || v == 240));
                    3: fd = (h == 10 && v == 479) || bnd;
                    4: fd = bnd;
                    6: fd = (h == 10 && v == 479);
                    default: if (f >= 7) fd = ($urandom_range(0, 199) == 0) || (bnd && (f % 2 == 1));
                endcase
                step(h, v, fd, rst, mk);
                if ((bnd && f >= 1 && f <= 6) || mk || rst) begin
                    @(posedge clk); #1;
                    if (mk) chk("rd_addr_h5_v2", rd_addr, 20'd1285);
                    if (rst) check_reset_values("midframe_reset");
                    if (bnd) begin
                        case (f)
                            1: chk("wb_after_first_swap", write_bank, 1);
                            2: chk("wb_after_second_swap", write_bank, 0);
                            3: begin
                                chk("wb_swap_on_boundary_fd", write_bank, 1);
                                chk("drop_on_boundary_fd", frame_dropped, 1);
                            end
                            4: chk("wb_no_swap_fd_at_boundary", write_bank, 1);
                            5: chk("wb_deferred_swap", write_bank, 0);
                            default: chk("wb_after_reset_swap", write_bank, 1);
                        endcase
                    end
                end
            end
        end
    endtask

    initial begin
        int d0;
        repeat (3) step(0, 0, 0, 1, 0);
        @(posedge clk); #1;
        check_reset_values("reset");
        check_en = 1;

        run_frame(0);
        chk("f0_write_bank", write_bank, 0);
        chk("f0_drops", obs_drops, 0);
        run_frame(1);
        d0 = obs_drops;
        run_frame(2);
        chk("f2_drop_count", obs_drops - d0, 1);
        for (int f = 3; f < 13; f++) run_frame(f);

        // Offset clamp on the small instance: 8x4 frame, last offset 31
        @(negedge clk);
        s_reset = 1'b0; s_hcount = 11'd1; s_vcount = 10'd1;
        for (int n = 1; n <= 40; n++) begin
            if (n > 1) @(negedge clk);
            if (n == 20 || n == 40) begin
                @(posedge clk); #1;
                chk(n == 20 ? "sat_count_19" : "sat_clamp_31", s_rd_addr, n == 20 ? 6'd51 : 6'd63);
            end
        end
        chk("sat_write_bank", s_write_bank, 0);
        chk("sat_pixel_black", s_pixel_out, 0);
        chk("sat_syncs", {s_hsync_out, s_vsync_out, s_blank_out, s_frame_dropped}, 4'b1100);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
